// File: rtl/pn_seq_axis_source.sv
// AXI4-Stream source of BPSK maximal-length PN chips as {Q,I} samples.
// Bursts of whole frames or continuous; tlast marks each frame end.
module pn_seq_axis_source #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int LFSR_WIDTH = 11,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = 11'h500,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 11'h001,
  parameter int AMPLITUDE = 16384
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_frames,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic        m00_axis_tlast,
  input  logic        m00_axis_tready
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int L = 2 ** LFSR_WIDTH - 1;
  localparam logic [31:0] POS = 32'(AMPLITUDE);
  localparam logic [31:0] NEG = 32'(-AMPLITUDE);
  localparam logic [LFSR_WIDTH-1:0] LAST = LFSR_WIDTH'(L - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_n;
  logic [LFSR_WIDTH-1:0] lfsr, lfsr_n;
  logic [LFSR_WIDTH-1:0] chip, chip_n;
  logic [15:0] nf, nf_n;
  logic [15:0] fc, fc_n;
  logic [DW-1:0] data, data_n;
  logic last, last_n;
  logic xfer;

  function automatic logic [DW-1:0] map(input logic c);
    return {{(DW-32){1'b0}}, (c ? NEG : POS)};
  endfunction

  assign xfer = (state == STREAM) && m00_axis_tready;

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    chip_n  = chip;
    nf_n    = nf;
    fc_n    = fc;
    data_n  = data;
    last_n  = last;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = STREAM;
          nf_n    = num_frames;
          lfsr_n  = LFSR_SEED;
          chip_n  = '0;
          fc_n    = '0;
          data_n  = map(LFSR_SEED[LFSR_WIDTH-1]);
          last_n  = 1'b0;
        end
      end
      STREAM: begin
        if (xfer && last) begin
          // frame boundary: every frame restarts from the seed
          chip_n = '0;
          lfsr_n = LFSR_SEED;
          fc_n   = fc + 16'd1;
          data_n = map(LFSR_SEED[LFSR_WIDTH-1]);
          last_n = 1'b0;
          if (stop || (nf != 16'd0 && fc + 16'd1 == nf))
            state_n = IDLE;
        end else if (xfer) begin
          lfsr_n = {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
          chip_n = chip + 1'b1;
          data_n = map(lfsr_n[LFSR_WIDTH-1]);
          last_n = (chip_n == LAST);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state <= IDLE;
      lfsr  <= LFSR_SEED;
      chip  <= '0;
      nf    <= '0;
      fc    <= '0;
      data  <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_n;
      chip  <= chip_n;
      nf    <= nf_n;
      fc    <= fc_n;
      data  <= data_n;
      last  <= last_n;
    end
  end

  assign busy            = (state == STREAM);
  assign m00_axis_tvalid = (state == STREAM);
  assign m00_axis_tlast  = last;
  assign m00_axis_tdata  = data;
  assign m00_axis_tstrb  = '1;
  assign frame_count     = fc;

endmodule

// File: tb/tb_pn_seq_axis_source.sv
// Directed bench: default 11-bit instance and a 3-bit instance
// with hand-derived chip patterns.
module tb_pn_seq_axis_source;

  localparam logic [63:0] P = 64'h0000_0000_0000_4000;
  localparam logic [63:0] N = 64'h0000_0000_FFFF_C000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rstn, a_start, a_stop, a_busy, a_tvalid, a_tlast, a_tready;
  logic [15:0] a_num, a_fc;
  logic [63:0] a_tdata;
  logic [7:0] a_tstrb;

  logic b_rstn, b_start, b_stop, b_busy, b_tvalid, b_tlast, b_tready;
  logic [15:0] b_num, b_fc;
  logic [63:0] b_tdata;
  logic [7:0] b_tstrb;

  pn_seq_axis_source u_a (
    .m00_axis_aclk(clk), .m00_axis_aresetn(a_rstn),
    .start(a_start), .stop(a_stop), .num_frames(a_num),
    .busy(a_busy), .frame_count(a_fc),
    .m00_axis_tvalid(a_tvalid), .m00_axis_tdata(a_tdata),
    .m00_axis_tstrb(a_tstrb), .m00_axis_tlast(a_tlast),
    .m00_axis_tready(a_tready)
  );

  pn_seq_axis_source #(
    .LFSR_WIDTH(3), .LFSR_TAPS(3'h6), .LFSR_SEED(3'h1)
  ) u_b (
    .m00_axis_aclk(clk), .m00_axis_aresetn(b_rstn),
    .start(b_start), .stop(b_stop), .num_frames(b_num),
    .busy(b_busy), .frame_count(b_fc),
    .m00_axis_tvalid(b_tvalid), .m00_axis_tdata(b_tdata),
    .m00_axis_tstrb(b_tstrb), .m00_axis_tlast(b_tlast),
    .m00_axis_tready(b_tready)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] q_data[$];
  logic q_last[$];
  bit pat[7] = '{0, 0, 1, 0, 1, 1, 1};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_b(input logic [15:0] nf);
    b_num = nf;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("b_latency", {63'd0, b_tvalid}, 64'd1);
  endtask

  // Runs while busy; records accepted beats and checks stall stability.
  task automatic collect(input int max_cyc, input bit rnd,
                         input int stop_beat, input bit spam);
    int cyc = 0;
    bit stall = 0;
    logic [63:0] pd = '0;
    logic pl = 1'b0;
    q_data.delete();
    q_last.delete();
    while (b_busy && cyc < max_cyc) begin
      b_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      b_stop = (stop_beat >= 0) && (q_data.size() >= stop_beat);
      b_start = spam && (cyc % 3 == 0);
      if (stall) begin
        chk("stall_data", b_tdata, pd);
        chk("stall_last", {63'd0, b_tlast}, {63'd0, pl});
      end
      if (b_tvalid && b_tready) begin
        q_data.push_back(b_tdata);
        q_last.push_back(b_tlast);
      end
      stall = b_tvalid && !b_tready;
      pd = b_tdata;
      pl = b_tlast;
      step();
      cyc++;
    end
    b_start = 1'b0;
    b_stop = 1'b0;
    b_tready = 1'b1;
    if (cyc >= max_cyc) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic check_seq(input string tag, input int n,
                           input logic [15:0] exp_fc);
    chk({tag, "_beats"}, 64'(q_data.size()), 64'(n));
    for (int k = 0; k < q_data.size() && k < n; k++) begin
      chk({tag, "_data"}, q_data[k], pat[k % 7] ? N : P);
      chk({tag, "_last"}, {63'd0, q_last[k]},
          {63'd0, (k % 7 == 6)});
    end
    chk({tag, "_fc"}, {48'd0, b_fc}, {48'd0, exp_fc});
    chk({tag, "_busy"}, {63'd0, b_busy}, 64'd0);
    chk({tag, "_valid"}, {63'd0, b_tvalid}, 64'd0);
  endtask

  initial begin
    int beats, nlast, lpos, cyc;
    logic [63:0] first[11];
    a_rstn = 0; a_start = 0; a_stop = 0; a_num = 0; a_tready = 1;
    b_rstn = 0; b_start = 0; b_stop = 0; b_num = 0; b_tready = 1;
    step();
    step();
    a_rstn = 1;
    b_rstn = 1;
    chk("rst_valid", {63'd0, a_tvalid}, 64'd0);
    chk("rst_last", {63'd0, a_tlast}, 64'd0);
    chk("rst_data", a_tdata, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_fc", {48'd0, a_fc}, 64'd0);
    chk("strb", {56'd0, a_tstrb}, 64'hFF);
    step();

    // default instance, one full 2047-chip frame
    a_num = 16'd1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("a_latency", {63'd0, a_tvalid}, 64'd1);
    beats = 0; nlast = 0; lpos = -1; cyc = 0;
    while (a_busy && cyc < 3000) begin
      if (a_tvalid && a_tready) begin
        if (beats < 11) first[beats] = a_tdata;
        if (a_tlast) begin
          nlast++;
          lpos = beats;
        end
        beats++;
      end
      step();
      cyc++;
    end
    if (cyc >= 3000) chk("a_timeout", 64'd1, 64'd0);
    for (int k = 0; k < 10; k++) chk("a_chip_pos", first[k], P);
    chk("a_chip10", first[10], N);
    chk("a_beats", 64'(beats), 64'd2047);
    chk("a_nlast", 64'(nlast), 64'd1);
    chk("a_lastpos", 64'(lpos), 64'd2046);
    chk("a_fc", {48'd0, a_fc}, 64'd1);
    chk("a_valid_end", {63'd0, a_tvalid}, 64'd0);

    // three frames, full throughput
    start_b(16'd3);
    collect(200, 0, -1, 0);
    check_seq("t2", 21, 16'd3);

    // same with random backpressure
    start_b(16'd3);
    collect(400, 1, -1, 0);
    check_seq("t3", 21, 16'd3);

    // continuous, stop raised on chip 2 of the fourth frame
    start_b(16'd0);
    collect(400, 0, 23, 0);
    check_seq("t4", 28, 16'd4);

    // reset mid-frame, then a fresh single-frame burst
    start_b(16'd0);
    step();
    step();
    step();
    chk("t5_pre_fc", {48'd0, b_fc}, 64'd0);
    chk("t5_chip3", b_tdata, P);
    b_rstn = 1'b0;
    step();
    chk("t5_valid", {63'd0, b_tvalid}, 64'd0);
    chk("t5_last", {63'd0, b_tlast}, 64'd0);
    chk("t5_data", b_tdata, 64'd0);
    chk("t5_busy", {63'd0, b_busy}, 64'd0);
    chk("t5_fc", {48'd0, b_fc}, 64'd0);
    b_rstn = 1'b1;
    step();
    start_b(16'd1);
    collect(100, 0, -1, 0);
    check_seq("t5", 7, 16'd1);

    // start spammed during the burst must not disturb it
    start_b(16'd2);
    collect(200, 0, -1, 1);
    check_seq("t6", 14, 16'd2);
    step();
    chk("t6_idle", {63'd0, b_busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
